// File: rtl/mc_control_seq.sv
// mc_control_seq: multi-cycle control sequencer for the MIPS-31 CPU.
// Steps the decoder's per-instruction control word through IF/ID/EX/MEM/WB.
// It gates the RF, DM and PC strobes per state, resolves branches and jumps,
// and waits on the IM, DM and mult/div handshakes under a watchdog.
// Optional build macro MC_PERF_CNT_EN adds the retired and stall_cyc counters.
//
// Handshake semantics: a request (im_r, dm_cs with dm_r/dm_w, or the
// mult/div operation started by md_start) is held while the sequencer sits in
// the waiting state. The matching ready (im_ready, dm_ready, md_done) is
// sampled on the rising edge. The transfer completes on the cycle where the
// request is up and ready=1, and the state advances on that edge. A ready is
// ignored outside its own waiting state.
module mc_control_seq #(
  parameter int M_W      = 9,
  parameter int ALUC_W   = 4,
  parameter int WAIT_MAX = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              im_ready,
  input  logic              dm_ready,
  input  logic              md_done,
  input  logic              zero,
  input  logic [M_W-1:0]    m_in,
  input  logic [ALUC_W-1:0] aluc_in,
  input  logic              rf_w_in,
  input  logic              dm_r_in,
  input  logic              dm_w_in,
  input  logic              md_in,
  input  logic              cls_beq,
  input  logic              cls_bne,
  input  logic              cls_j,
  input  logic              cls_jr,
  output logic              im_r,
  output logic              ir_we,
  output logic              pc_we,
  output logic [1:0]        pc_sel,
  output logic              rf_w,
  output logic              dm_cs,
  output logic              dm_r,
  output logic              dm_w,
  output logic              md_start,
  output logic [M_W-1:0]    m,
  output logic [ALUC_W-1:0] aluc,
  output logic [2:0]        state,
`ifdef MC_PERF_CNT_EN
  output logic [31:0]       retired,
  output logic [31:0]       stall_cyc,
`endif
  output logic              fault
);

  // A zero WAIT_MAX disables the watchdog. A 1-bit counter is kept so the
  // widths stay legal in that case.
  localparam int CNT_W = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
  // The trip happens when the last permitted wait cycle also sees no ready.
  localparam logic [CNT_W-1:0] CNT_LAST = (WAIT_MAX > 0) ? CNT_W'(WAIT_MAX - 1) : '0;

  typedef enum logic [2:0] {
    S_IF    = 3'd0,
    S_ID    = 3'd1,
    S_EX    = 3'd2,
    S_MEM   = 3'd3,
    S_WB    = 3'd4,
    S_FAULT = 3'd7
  } state_t;

  typedef struct packed {
    logic rf_w;
    logic dm_r;
    logic dm_w;
    logic md;
    logic beq;
    logic bne;
    logic j;
    logic jr;
  } ctrl_t;

  state_t            state_q, state_d;
  ctrl_t             ctrl_q, ctrl_d;
  logic [M_W-1:0]    m_q, m_d;
  logic [ALUC_W-1:0] aluc_q, aluc_d;
  logic [1:0]        pc_sel_q, pc_sel_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic              ex_first_q, ex_first_d;

  logic              waiting;   // the current state is waiting on a handshake
  logic              hs_ready;  // ready of the handshake being waited on
  logic              br_taken;
  logic [1:0]        sel_res;

  // Branch/jump resolution from the latched class bits and the live ALU zero flag.
  always_comb begin
    br_taken = (ctrl_q.beq && zero) || (ctrl_q.bne && !zero);
    sel_res  = 2'd0;
    if (br_taken)       sel_res = 2'd1;
    else if (ctrl_q.j)  sel_res = 2'd2;
    else if (ctrl_q.jr) sel_res = 2'd3;
  end

  // Next-state, latches, watchdog and combinational strobes.
  always_comb begin
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    m_d        = m_q;
    aluc_d     = aluc_q;
    pc_sel_d   = pc_sel_q;
    wait_cnt_d = wait_cnt_q;
    waiting    = 1'b0;
    hs_ready   = 1'b0;
    im_r       = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    rf_w       = 1'b0;
    dm_cs      = 1'b0;
    dm_r       = 1'b0;
    dm_w       = 1'b0;
    md_start   = 1'b0;
    pc_sel     = pc_sel_q;

    case (state_q)
      S_IF: begin
        im_r     = 1'b1;
        waiting  = 1'b1;
        hs_ready = im_ready;
        if (im_ready) begin
          ir_we   = 1'b1;
          state_d = S_ID;
        end
      end
      S_ID: begin
        m_d      = m_in;
        aluc_d   = aluc_in;
        ctrl_d   = '{rf_w: rf_w_in, dm_r: dm_r_in, dm_w: dm_w_in, md: md_in,
                     beq: cls_beq, bne: cls_bne, j: cls_j, jr: cls_jr};
        pc_sel_d = 2'd0;
        state_d  = S_EX;
      end
      S_EX: begin
        md_start = ex_first_q && ctrl_q.md;
        waiting  = ctrl_q.md;
        hs_ready = md_done;
        if (!ctrl_q.md || md_done) begin
          // Present the resolved select in the same cycle as a possible pc_we.
          pc_sel   = sel_res;
          pc_sel_d = sel_res;
          if (ctrl_q.dm_r || ctrl_q.dm_w) begin
            state_d = S_MEM;
          end else if (ctrl_q.rf_w) begin
            state_d = S_WB;
          end else begin
            pc_we   = 1'b1;
            state_d = S_IF;
          end
        end
      end
      S_MEM: begin
        dm_cs    = 1'b1;
        dm_w     = ctrl_q.dm_w;
        // An illegal word with both bits set is treated as a store.
        dm_r     = ctrl_q.dm_r && !ctrl_q.dm_w;
        waiting  = 1'b1;
        hs_ready = dm_ready;
        if (dm_ready) begin
          if (ctrl_q.dm_w) begin
            pc_we   = 1'b1;
            state_d = S_IF;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        rf_w    = 1'b1;
        pc_we   = 1'b1;
        state_d = S_IF;
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_IF;
      end
    endcase

    // Watchdog. A ready on the last permitted cycle still wins.
    if ((WAIT_MAX > 0) && waiting && !hs_ready && (wait_cnt_q == CNT_LAST)) begin
      state_d = S_FAULT;
    end

    if (state_d != state_q) begin
      wait_cnt_d = '0;
    end else if ((WAIT_MAX > 0) && waiting) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end

    // No strobe may fire while reset is held.
    if (rst) begin
      im_r     = 1'b0;
      ir_we    = 1'b0;
      pc_we    = 1'b0;
      rf_w     = 1'b0;
      dm_cs    = 1'b0;
      dm_r     = 1'b0;
      dm_w     = 1'b0;
      md_start = 1'b0;
      pc_sel   = 2'd0;
    end
  end

  assign ex_first_d = (state_d == S_EX) && (state_q != S_EX);

  // State and latched control word registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IF;
      ctrl_q     <= '0;
      m_q        <= '0;
      aluc_q     <= '0;
      pc_sel_q   <= 2'd0;
      wait_cnt_q <= '0;
      ex_first_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      m_q        <= m_d;
      aluc_q     <= aluc_d;
      pc_sel_q   <= pc_sel_d;
      wait_cnt_q <= wait_cnt_d;
      ex_first_q <= ex_first_d;
    end
  end

  assign m     = m_q;
  assign aluc  = aluc_q;
  assign state = state_q;
  assign fault = (state_q == S_FAULT);

`ifdef MC_PERF_CNT_EN
  logic [31:0] retired_q, stall_cyc_q;

  // Retired-instruction and handshake-stall counters, wrapping modulo 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      retired_q   <= '0;
      stall_cyc_q <= '0;
    end else begin
      retired_q   <= retired_q + {31'd0, pc_we};
      stall_cyc_q <= stall_cyc_q + {31'd0, (waiting && !hs_ready)};
    end
  end

  assign retired   = retired_q;
  assign stall_cyc = stall_cyc_q;
`endif

endmodule

// File: tb/tb_mc_control_seq.sv
// Directed testbench for mc_control_seq (default build, WAIT_MAX=15).
// Each cycle the strobe/state vector is compared against a queue of
// hand-computed expected vectors.
module tb_mc_control_seq;

  localparam int M_W      = 9;
  localparam int ALUC_W   = 4;
  localparam int WAIT_MAX = 15;
  localparam int NEVER    = 1000;

  logic              clk;
  logic              rst;
  logic              im_ready, dm_ready, md_done, zero;
  logic [M_W-1:0]    m_in;
  logic [ALUC_W-1:0] aluc_in;
  logic              rf_w_in, dm_r_in, dm_w_in, md_in;
  logic              cls_beq, cls_bne, cls_j, cls_jr;
  logic              im_r, ir_we, pc_we;
  logic [1:0]        pc_sel;
  logic              rf_w, dm_cs, dm_r, dm_w, md_start;
  logic [M_W-1:0]    m;
  logic [ALUC_W-1:0] aluc;
  logic [2:0]        state;
  logic              fault;
`ifdef MC_PERF_CNT_EN
  logic [31:0]       retired, stall_cyc;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // {state, pc_we, pc_sel, rf_w, dm_cs, dm_r, dm_w, md_start, im_r, ir_we}
  logic [12:0] exp_q[$];

  mc_control_seq #(.M_W(M_W), .ALUC_W(ALUC_W), .WAIT_MAX(WAIT_MAX)) dut (
    .clk      (clk),
    .rst      (rst),
    .im_ready (im_ready),
    .dm_ready (dm_ready),
    .md_done  (md_done),
    .zero     (zero),
    .m_in     (m_in),
    .aluc_in  (aluc_in),
    .rf_w_in  (rf_w_in),
    .dm_r_in  (dm_r_in),
    .dm_w_in  (dm_w_in),
    .md_in    (md_in),
    .cls_beq  (cls_beq),
    .cls_bne  (cls_bne),
    .cls_j    (cls_j),
    .cls_jr   (cls_jr),
    .im_r     (im_r),
    .ir_we    (ir_we),
    .pc_we    (pc_we),
    .pc_sel   (pc_sel),
    .rf_w     (rf_w),
    .dm_cs    (dm_cs),
    .dm_r     (dm_r),
    .dm_w     (dm_w),
    .md_start (md_start),
    .m        (m),
    .aluc     (aluc),
    .state    (state),
`ifdef MC_PERF_CNT_EN
    .retired  (retired),
    .stall_cyc(stall_cyc),
`endif
    .fault    (fault)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [12:0] obs_vec();
    return {state, pc_we, pc_sel, rf_w, dm_cs, dm_r, dm_w, md_start, im_r, ir_we};
  endfunction

  task automatic push_exp(input logic [2:0] st, input logic pw, input logic [1:0] ps,
                          input logic rw, input logic cs, input logic dr, input logic dw,
                          input logic ms, input logic ir, input logic iw);
    exp_q.push_back({st, pw, ps, rw, cs, dr, dw, ms, ir, iw});
  endtask

  task automatic exp_if(input logic [1:0] ps, input logic iw);
    push_exp(3'd0, 1'b0, ps, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, iw);
  endtask
  task automatic exp_id(input logic [1:0] ps);
    push_exp(3'd1, 1'b0, ps, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic exp_ex(input logic pw, input logic [1:0] ps, input logic ms);
    push_exp(3'd2, pw, ps, 1'b0, 1'b0, 1'b0, 1'b0, ms, 1'b0, 1'b0);
  endtask
  task automatic exp_mem(input logic pw, input logic dr, input logic dw);
    push_exp(3'd3, pw, 2'd0, 1'b0, 1'b1, dr, dw, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic exp_wb();
    push_exp(3'd4, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic exp_fault();
    push_exp(3'd7, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Driver: decoder control word for the next instruction.
  task automatic set_word(input logic rw, input logic dr, input logic dw, input logic md,
                          input logic beq, input logic bne, input logic j, input logic jr);
    rf_w_in = rw; dm_r_in = dr; dm_w_in = dw; md_in = md;
    cls_beq = beq; cls_bne = bne; cls_j = j; cls_jr = jr;
  endtask

  // Driver + scoreboard: run n cycles from the post-edge point, raising each
  // ready from its given cycle index on, and checking every cycle at negedge.
  task automatic run_cycles(input string name, input int n, input int im_at,
                            input int dm_at, input int md_at);
    logic [12:0] e;
    for (int k = 0; k < n; k++) begin
      im_ready = (k >= im_at);
      dm_ready = (k >= dm_at);
      md_done  = (k >= md_at);
      @(negedge clk);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 13'bx;
      check_eq($sformatf("%s c%0d", name, k), {19'd0, obs_vec()}, {19'd0, e});
      @(posedge clk);
      #1;
    end
    im_ready = 1'b0;
    dm_ready = 1'b0;
    md_done  = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    im_ready = 1'b0; dm_ready = 1'b0; md_done = 1'b0; zero = 1'b0;
    m_in = '0; aluc_in = '0;
    set_word(0, 0, 0, 0, 0, 0, 0, 0);

    // Reset: two cycles, check the reset state during the second one.
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("rst state",  {29'd0, state},  32'd0);
    check_eq("rst fault",  {31'd0, fault},  32'd0);
    check_eq("rst strobes", {19'd0, obs_vec()}, 32'd0);
    check_eq("rst m",      {23'd0, m},      32'd0);
    check_eq("rst aluc",   {28'd0, aluc},   32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // add: IF ID EX WB
    set_word(1, 0, 0, 0, 0, 0, 0, 0); m_in = 9'h1A5; aluc_in = 4'h3;
    exp_if(2'd0, 1'b1); exp_id(2'd0); exp_ex(1'b0, 2'd0, 1'b0); exp_wb();
    run_cycles("add", 4, 0, NEVER, NEVER);
    check_eq("add m",    {23'd0, m},    32'h1A5);
    check_eq("add aluc", {28'd0, aluc}, 32'h3);

    // beq taken / not taken, bne taken / not taken, j, jr: 3 cycles each.
    set_word(0, 0, 0, 0, 1, 0, 0, 0); zero = 1'b1; m_in = 9'h0F0; aluc_in = 4'h6;
    exp_if(2'd0, 1'b1); exp_id(2'd0); exp_ex(1'b1, 2'd1, 1'b0);
    run_cycles("beq_t", 3, 0, NEVER, NEVER);
    check_eq("beq m", {23'd0, m}, 32'h0F0);

    zero = 1'b0;
    exp_if(2'd1, 1'b1); exp_id(2'd1); exp_ex(1'b1, 2'd0, 1'b0);
    run_cycles("beq_nt", 3, 0, NEVER, NEVER);

    set_word(0, 0, 0, 0, 0, 1, 0, 0); zero = 1'b0;
    exp_if(2'd0, 1'b1); exp_id(2'd0); exp_ex(1'b1, 2'd1, 1'b0);
    run_cycles("bne_t", 3, 0, NEVER, NEVER);

    zero = 1'b1;
    exp_if(2'd1, 1'b1); exp_id(2'd1); exp_ex(1'b1, 2'd0, 1'b0);
    run_cycles("bne_nt", 3, 0, NEVER, NEVER);

    set_word(0, 0, 0, 0, 0, 0, 1, 0); zero = 1'b0;
    exp_if(2'd0, 1'b1); exp_id(2'd0); exp_ex(1'b1, 2'd2, 1'b0);
    run_cycles("j", 3, 0, NEVER, NEVER);

    set_word(0, 0, 0, 0, 0, 0, 0, 1);
    exp_if(2'd2, 1'b1); exp_id(2'd2); exp_ex(1'b1, 2'd3, 1'b0);
    run_cycles("jr", 3, 0, NEVER, NEVER);

    // lw with dm_ready low for 3 MEM cycles: MEM held 4 cycles, then WB.
    set_word(1, 1, 0, 0, 0, 0, 0, 0);
    exp_if(2'd3, 1'b1); exp_id(2'd3); exp_ex(1'b0, 2'd0, 1'b0);
    for (int i = 0; i < 4; i++) exp_mem(1'b0, 1'b1, 1'b0);
    exp_wb();
    run_cycles("lw", 8, 0, 6, NEVER);

    // mult/div: md_start on first EX cycle only, EX held until md_done, then WB.
    set_word(1, 0, 0, 1, 0, 0, 0, 0);
    exp_if(2'd0, 1'b1); exp_id(2'd0); exp_ex(1'b0, 2'd0, 1'b1);
    for (int i = 0; i < 4; i++) exp_ex(1'b0, 2'd0, 1'b0);
    exp_wb();
    run_cycles("md", 8, 0, NEVER, 6);

    // sw: one waiting MEM cycle, then pc_we and back to IF.
    set_word(0, 0, 1, 0, 0, 0, 0, 0);
    exp_if(2'd0, 1'b1); exp_id(2'd0); exp_ex(1'b0, 2'd0, 1'b0);
    exp_mem(1'b0, 1'b0, 1'b1); exp_mem(1'b1, 1'b0, 1'b1);
    run_cycles("sw", 5, 0, 4, NEVER);

    // Illegal word (load and store): acts as a store, no WB despite rf_w.
    set_word(1, 1, 1, 0, 0, 0, 0, 0);
    exp_if(2'd0, 1'b1); exp_id(2'd0); exp_ex(1'b0, 2'd0, 1'b0);
    exp_mem(1'b1, 1'b0, 1'b1);
    run_cycles("ldst", 4, 0, 3, NEVER);

    // Watchdog: no im_ready for 15 IF cycles trips FAULT; late ready ignored.
    set_word(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 15; i++) exp_if(2'd0, 1'b0);
    for (int i = 0; i < 3; i++) exp_fault();
    run_cycles("wdog", 18, 16, NEVER, NEVER);
    check_eq("wdog fault", {31'd0, fault}, 32'd1);

    // rst clears FAULT.
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("unfault state", {29'd0, state}, 32'd0);
    check_eq("unfault fault", {31'd0, fault}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // im_ready on the 15th IF cycle wins over the watchdog.
    for (int i = 0; i < 14; i++) exp_if(2'd0, 1'b0);
    exp_if(2'd0, 1'b1); exp_id(2'd0); exp_ex(1'b0, 2'd0, 1'b0); exp_wb();
    run_cycles("wdog_edge", 18, 14, NEVER, NEVER);
    check_eq("wdog_edge fault", {31'd0, fault}, 32'd0);

    // rst while a store waits in MEM aborts it.
    set_word(0, 0, 1, 0, 0, 0, 0, 0); m_in = 9'h155; aluc_in = 4'hA;
    exp_if(2'd0, 1'b1); exp_id(2'd0); exp_ex(1'b0, 2'd0, 1'b0); exp_mem(1'b0, 1'b0, 1'b1);
    run_cycles("sw_abort", 4, 0, NEVER, NEVER);
    check_eq("sw_abort m", {23'd0, m}, 32'h155);
    rst = 1'b1;
    @(negedge clk);
    check_eq("abort rst dm_cs", {31'd0, dm_cs}, 32'd0);
    check_eq("abort rst pc_we", {31'd0, pc_we}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("abort state", {29'd0, state}, 32'd0);
    check_eq("abort dm_cs", {31'd0, dm_cs}, 32'd0);
    check_eq("abort dm_w",  {31'd0, dm_w},  32'd0);
    check_eq("abort pc_we", {31'd0, pc_we}, 32'd0);
    check_eq("abort m",     {23'd0, m},     32'd0);
    check_eq("abort aluc",  {28'd0, aluc},  32'd0);
    check_eq("abort exp_q empty", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
